// File: rtl/key_event_gen_pkg.sv
// key_event_gen_pkg: FSM state encodings and default 50 MHz timing for the key front end
package key_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } key_state_t;

    localparam int DEF_DEB_CYCLES    = 1000000;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;
    localparam int DEF_ACTIVE_LOW    = 1;

endpackage

// File: rtl/key_event_gen_debounce.sv
// key_sync_debounce: 2-FF synchroniser, polarity normalisation and counter debounce with rise/fall strobes
module key_sync_debounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_kin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LIM = CW'(DEB_CYCLES - 1);
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_sample;

    assign w_sample = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;
    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

    // Two-stage synchroniser, reset to the released raw level so no false press follows reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RAW_RELEASED;
            r_s2 <= RAW_RELEASED;
        end else begin
            r_s1 <= i_kin;
            r_s2 <= r_s1;
        end
    end

    // Flip the stable level only after DEB_CYCLES consecutive mismatching samples; strobe the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LIM) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
                r_rise  <= ~r_level;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: debounced key with press/release/short/long/auto-repeat event pulses
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kin,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic holding
);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LIM  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic          w_level;
    logic          w_rise;
    logic          w_fall;
    key_state_t    r_state;
    logic [HW-1:0] r_hold_cnt;
    logic [RW-1:0] r_rep_cnt;

    key_sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_kin  (kin),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Press classifier; a debounced fall always takes priority over long expiry or repeat wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_rep_cnt     <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            holding       <= 1'b0;
        end else begin
            key_level     <= w_level;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        press_pulse <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (r_hold_cnt == HOLD_LIM) begin
                        long_pulse <= 1'b1;
                        holding    <= 1'b1;
                        r_rep_cnt  <= '0;
                        r_state    <= ST_LONG;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (w_fall) begin
                        release_pulse <= 1'b1;
                        holding       <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (REPEAT_CYCLES > 0) begin
                        repeat_pulse <= (r_rep_cnt == REP_LIM);
                        r_rep_cnt    <= (r_rep_cnt == REP_LIM) ? '0 : r_rep_cnt + 1'b1;
                    end
                end
                default: begin
                    holding <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
Per-key front end feeding the LED key-control logic. It synchronises one raw push-button input, debounces it with a cycle counter, and classifies each press. It emits single-cycle event pulses: press, release, short-click, long-press and auto-repeat. Downstream logic consumes these pulses directly instead of doing its own edge detection.

Parameters:
DEB_CYCLES, 1000000, stable cycles required before the debounced level changes (20 ms at 50 MHz); minimum 2
LONG_CYCLES, 50000000, cycles from press_pulse to long_pulse (1 s); must be greater than DEB_CYCLES
REPEAT_CYCLES, 10000000, period of repeat_pulse while in LONG state (200 ms); 0 disables repeat
ACTIVE_LOW, 1, 1 means raw kin=0 is pressed; 0 means kin=1 is pressed

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
kin  in  1  raw asynchronous key input
key_level  out  1  debounced level, 1 = pressed
press_pulse  out  1  one-cycle pulse on debounced press
release_pulse  out  1  one-cycle pulse on debounced release
short_pulse  out  1  one-cycle pulse on release when no long_pulse fired during that press
long_pulse  out  1  one-cycle pulse when hold reaches LONG_CYCLES
repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while held after long_pulse
holding  out  1  1 while in LONG state

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered. Reset value of every output is 0.
- Synchroniser: 2-FF. Reset value is the released level (1 if ACTIVE_LOW, else 0). The input is polarity-normalised after the synchroniser.
- Debounce:
  - Counter width is $clog2(DEB_CYCLES+1).
  - When the normalised sample equals the stable level, the counter clears to 0.
  - Otherwise it increments. On the edge where counter == DEB_CYCLES-1 and mismatch persists, the stable level flips and the counter clears.
  - Latency from a kin change to key_level is DEB_CYCLES+2 clk cycles.
  - Any glitch shorter than DEB_CYCLES cycles produces no change and no pulse.
- FSM states: IDLE, PRESSED, LONG.
- IDLE: on debounced rise, assert press_pulse and go to PRESSED. press_pulse is asserted in the same cycle key_level goes to 1. Clear hold_cnt.
- PRESSED:
  - hold_cnt increments each cycle.
  - When hold_cnt == LONG_CYCLES-1, assert long_pulse, go to LONG, clear rep_cnt.
  - So long_pulse occurs LONG_CYCLES cycles after press_pulse.
- LONG:
  - rep_cnt increments and wraps to 0 at REPEAT_CYCLES-1. repeat_pulse is asserted on the wrap.
  - Repeats fall at long_pulse + k*REPEAT_CYCLES, for k = 1, 2, ...
  - If REPEAT_CYCLES == 0, rep_cnt is held at 0 and repeat_pulse is never asserted.
  - holding = 1 in this state.
- Debounced fall in PRESSED: assert release_pulse and short_pulse together, then go to IDLE.
- Debounced fall in LONG: assert release_pulse only, then go to IDLE.
- Simultaneous debounced fall and long expiry in PRESSED: the release wins. Assert release_pulse + short_pulse, no long_pulse, go to IDLE.
- Simultaneous debounced fall and repeat wrap in LONG: release wins. Assert release_pulse only, no repeat_pulse.
- Pulse exclusivity: at most one of press/long/repeat per cycle. release_pulse coincides only with short_pulse.
- Counter width rules: hold_cnt is $clog2(LONG_CYCLES) bits and never exceeds LONG_CYCLES-1. rep_cnt is $clog2(REPEAT_CYCLES+1) bits.
- Reset mid-operation:
  - Everything returns to IDLE with outputs at 0 and the stable level released.
  - If the key is still held after reset deasserts, it is re-debounced and produces a fresh press_pulse after DEB_CYCLES+2 cycles.
  - No release_pulse or short_pulse is emitted for the press interrupted by reset.

Decomposition:
- Shared include/package key_defs: FSM state encodings (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2) and default timing constants (DEB/LONG/REPEAT cycle counts for 50 MHz).
- One natural sub-module: key_sync_debounce.
  - Contents: synchroniser, polarity normalisation, debounce counter, stable level.
  - Outputs: the stable level plus rise and fall strobes.
  - Parameters: DEB_CYCLES, ACTIVE_LOW.
- key_event_gen instantiates key_sync_debounce and holds the FSM and the hold and repeat counters.

Test Plan:
Bench parameters for all scenarios: DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.
- Glitch: kin low for 3 cycles, then high -> key_level stays 0; no pulse of any kind.
- Short click: kin low at cycle T, high at T+10 -> press_pulse and key_level=1 at T+6; release_pulse + short_pulse at T+16; no long_pulse.
- Long hold with repeats: kin low at T, held 50 cycles -> press_pulse at T+6; long_pulse at T+26; holding=1 from T+26; repeat_pulse at T+34 and T+42; on release, release_pulse with short_pulse=0.
- Release coincident with long expiry: release timed so the debounced fall lands at press+20 -> release_pulse + short_pulse in that cycle; long_pulse never asserted.
- Bouncy press: kin toggles every 2 cycles for 10 cycles, then stays low -> exactly one press_pulse, 6 cycles after the last toggle.
- Reset mid-hold: assert rst_n=0 while in LONG with kin still low -> all outputs 0 immediately; after release of reset, press_pulse 6 cycles later; no release_pulse in between.
